hazard_fwd_unit: RTL and testbench

- Produces the `aluselectA`/`aluselectB` forwarding selects consumed by the exec stage.
- Produces the load-use stall and bubble controls for the IF/ID and ID/EX pipeline registers.
- Shadows the destination register, write-enable and load flag of the instructions in EX and MEM.
- Registers the selects so they are valid for the whole cycle the consumer occupies EX.
- Sits beside decode and drives both decode and exec.

---
 rtl/hazard_fwd_unit_pkg.sv | 22 ++
 rtl/hazard_fwd_unit_if.sv | 32 +++
 rtl/hazard_fwd_unit_fwd_match.sv | 40 ++++
 rtl/hazard_fwd_unit.sv | 77 +++++++
 tb/tb_hazard_fwd_unit.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/hazard_fwd_unit_pkg.sv
// Shared pipeline-hazard types: forwarding select codes, register index width, stage shadow entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pipe_pkg;

    localparam int REG_W = 5;
    localparam int SEL_W = 2;

    // Exec operand source selects.
    localparam logic [SEL_W-1:0] SEL_RF    = 2'd0;  // register-file value
    localparam logic [SEL_W-1:0] SEL_EXMEM = 2'd1;  // priorALUresult
    localparam logic [SEL_W-1:0] SEL_MEMWB = 2'd2;  // ALUwriteback
    localparam logic [SEL_W-1:0] SEL_ZERO  = 2'd3;  // reserved, never driven

    // Destination info carried alongside an instruction as it moves down the pipe.
    typedef struct packed {
        logic [REG_W-1:0] rw;
        logic             wr;
        logic             ld;
    } stage_dst_t;

endpackage

// File: rtl/hazard_fwd_unit_if.sv
// Decode-side bundle between decode/exec and the hazard/forwarding unit.
// Latency: selects are registered (1 cycle); stall/bubble are combinational.
// Backpressure: stall holds PC and IF/ID; bubble loads a NOP into ID/EX.
interface hazard_fwd_unit_if #(
    parameter int REG_W = pipe_pkg::REG_W,
    parameter int SEL_W = pipe_pkg::SEL_W
);
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic [REG_W-1:0] id_rw;
    logic             id_regwr;
    logic             id_memtoreg;
    logic             flush;
    logic [SEL_W-1:0] aluselectA;
    logic [SEL_W-1:0] aluselectB;
    logic             stall;
    logic             bubble;

    // Decode/exec side.
    modport master (
        output id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_regwr, id_memtoreg, flush,
        input  aluselectA, aluselectB, stall, bubble
    );

    // Hazard unit side.
    modport slave (
        input  id_rs, id_rt, id_use_rs, id_use_rt, id_rw, id_regwr, id_memtoreg, flush,
        output aluselectA, aluselectB, stall, bubble
    );
endinterface

// File: rtl/hazard_fwd_unit_fwd_match.sv
// Compares one decode source index against the EX and MEM shadow entries.
// Latency: combinational.
// Backpressure: none; stall_hit feeds the unit's stall decision.
// With HAZARD_FWD_EN defined only an EX-stage load hit stalls; otherwise any producer hit stalls.
module fwd_match
    import pipe_pkg::*;
(
    input  logic [REG_W-1:0] src,
    input  logic             use_src,
    input  stage_dst_t       ex,
    input  logic [REG_W-1:0] mem_rw,
    input  logic             mem_wr,
    output logic [SEL_W-1:0] sel,
    output logic             stall_hit
);

    logic ex_hit;
    logic mem_hit;

    // Producer matches, youngest (EX) first; r0 never matches.
    always_comb begin
        ex_hit  = use_src && ex.wr && (ex.rw != '0) && (src == ex.rw);
        mem_hit = use_src && mem_wr && (mem_rw != '0) && (src == mem_rw);
        sel     = SEL_RF;
        if (ex_hit) begin
            sel = SEL_EXMEM;
        end else if (mem_hit) begin
            sel = SEL_MEMWB;
        end
`ifdef HAZARD_FWD_EN
        // ALU results forward from EX; only a load in EX has no value yet.
        stall_hit = ex_hit && ex.ld;
`else
        // No bypass: wait until the producer reaches WB. The load term is a
        // subset of ex_hit and is kept so both builds read the same inputs.
        stall_hit = (ex_hit && ex.ld) || ex_hit || mem_hit;
`endif
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Hazard detection and operand forwarding selects for a 5-stage pipe (optional macro HAZARD_FWD_EN).
// Latency: aluselectA/B registered, valid the cycle the consumer sits in EX; stall/bubble combinational.
// Backpressure: stall freezes PC and IF/ID; bubble zeroes the ID/EX entry; flush overrides stall.
module hazard_fwd_unit
    import pipe_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    hazard_fwd_unit_if.slave   hif
);

    stage_dst_t       id_dst;
    stage_dst_t       ex_q;
    logic [REG_W-1:0] mem_rw_q;
    logic             mem_wr_q;
    logic [SEL_W-1:0] sel_a;
    logic [SEL_W-1:0] sel_b;
    logic [SEL_W-1:0] sel_a_q;
    logic [SEL_W-1:0] sel_b_q;
    logic             hit_a;
    logic             hit_b;
    logic             stall_c;
    logic             bubble_c;

    assign id_dst = '{rw: hif.id_rw, wr: hif.id_regwr, ld: hif.id_memtoreg};

    fwd_match u_match_rs (
        .src       (hif.id_rs),
        .use_src   (hif.id_use_rs),
        .ex        (ex_q),
        .mem_rw    (mem_rw_q),
        .mem_wr    (mem_wr_q),
        .sel       (sel_a),
        .stall_hit (hit_a)
    );

    fwd_match u_match_rt (
        .src       (hif.id_rt),
        .use_src   (hif.id_use_rt),
        .ex        (ex_q),
        .mem_rw    (mem_rw_q),
        .mem_wr    (mem_wr_q),
        .sel       (sel_b),
        .stall_hit (hit_b)
    );

    // A killed instruction never needs to wait, so flush suppresses stall but still bubbles.
    always_comb begin
        stall_c  = (hit_a || hit_b) && !hif.flush;
        bubble_c = stall_c || hif.flush;
    end

    // Shadow the EX/MEM destinations and register the selects alongside ID/EX.
    // Without HAZARD_FWD_EN every producer match stalls (bubble), so the
    // registered selects are always SEL_RF in that build.
    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q     <= '0;
            mem_rw_q <= '0;
            mem_wr_q <= 1'b0;
            sel_a_q  <= SEL_RF;
            sel_b_q  <= SEL_RF;
        end else begin
            mem_rw_q <= ex_q.rw;
            mem_wr_q <= ex_q.wr;
            ex_q     <= bubble_c ? stage_dst_t'('0) : id_dst;
            sel_a_q  <= bubble_c ? SEL_RF : sel_a;
            sel_b_q  <= bubble_c ? SEL_RF : sel_b;
        end
    end

    assign hif.stall      = stall_c;
    assign hif.bubble     = bubble_c;
    assign hif.aluselectA = sel_a_q;
    assign hif.aluselectB = sel_b_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit; expectations follow the HAZARD_FWD_EN build setting.
// Latency: inputs change on negedge, combinational outputs sampled #1 later, selects #1 after posedge.
// Backpressure: instructions are held in decode while stall is high (bounded).
module tb_hazard_fwd_unit;
    import pipe_pkg::*;

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    hazard_fwd_unit_if hif ();

    hazard_fwd_unit dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                         input logic urt, input logic [4:0] rw, input logic wr,
                         input logic ld, input logic fl);
        hif.id_rs       = rs;
        hif.id_rt       = rt;
        hif.id_use_rs   = urs;
        hif.id_use_rt   = urt;
        hif.id_rw       = rw;
        hif.id_regwr    = wr;
        hif.id_memtoreg = ld;
        hif.flush       = fl;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Issue one instruction into decode; hold it while stalled (bounded to 5 cycles).
    // Returns at posedge+1 of the cycle it entered EX.
    task automatic send(input logic [4:0] rs, input logic [4:0] rt, input logic urs,
                        input logic urt, input logic [4:0] rw, input logic wr,
                        input logic ld, output int stalls, output int bubbles);
        logic s;
        stalls  = 0;
        bubbles = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive(rs, rt, urs, urt, rw, wr, ld, 1'b0);
            #1;
            s = hif.stall;
            if (hif.bubble === 1'b1) bubbles++;
            @(posedge clk);
            #1;
            if (s !== 1'b1) break;
            stalls++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(3, 3, 1, 1, 3, 1, 1, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        n_checks++; if (hif.aluselectA !== 2'd0) begin n_fail++; $display("FAIL reset_selA: got %0d expected 0", hif.aluselectA); end
        n_checks++; if (hif.aluselectB !== 2'd0) begin n_fail++; $display("FAIL reset_selB: got %0d expected 0", hif.aluselectB); end
        n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", hif.stall); end
        n_checks++; if (hif.bubble !== 1'b0) begin n_fail++; $display("FAIL reset_bubble: got %b expected 0", hif.bubble); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_ex_fwd();
        int st, bb;
        do_reset();
        send(1, 2, 1, 1, 3, 1, 0, st, bb);                // add r3,r1,r2
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL ex_fwd_add_stalls: got %0d expected 0", st); end
        send(3, 5, 1, 1, 4, 1, 0, st, bb);                // sub r4,r3,r5
        n_checks++; if (st !== (FWD ? 0 : 2)) begin n_fail++; $display("FAIL ex_fwd_stalls: got %0d expected %0d", st, FWD ? 0 : 2); end
        n_checks++; if (bb !== st) begin n_fail++; $display("FAIL ex_fwd_bubbles: got %0d expected %0d", bb, st); end
        n_checks++; if (hif.aluselectA !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL ex_fwd_selA: got %0d expected %0d", hif.aluselectA, FWD ? 1 : 0); end
        n_checks++; if (hif.aluselectB !== 2'd0) begin n_fail++; $display("FAIL ex_fwd_selB: got %0d expected 0", hif.aluselectB); end
    endtask

    task automatic test_mem_fwd();
        int st, bb;
        do_reset();
        send(1, 2, 1, 1, 3, 1, 0, st, bb);                // add r3
        send(0, 0, 0, 0, 0, 0, 0, st, bb);                // nop
        send(7, 3, 1, 1, 6, 1, 0, st, bb);                // or r6,r7,r3
        n_checks++; if (st !== (FWD ? 0 : 1)) begin n_fail++; $display("FAIL mem_fwd_stalls: got %0d expected %0d", st, FWD ? 0 : 1); end
        n_checks++; if (hif.aluselectA !== 2'd0) begin n_fail++; $display("FAIL mem_fwd_selA: got %0d expected 0", hif.aluselectA); end
        n_checks++; if (hif.aluselectB !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL mem_fwd_selB: got %0d expected %0d", hif.aluselectB, FWD ? 2 : 0); end
    endtask

    task automatic test_load_use();
        int st, bb;
        do_reset();
        send(1, 0, 1, 0, 8, 1, 1, st, bb);                // lw r8,0(r1)
        send(8, 8, 1, 1, 9, 1, 0, st, bb);                // add r9,r8,r8
        n_checks++; if (st !== (FWD ? 1 : 2)) begin n_fail++; $display("FAIL load_use_stalls: got %0d expected %0d", st, FWD ? 1 : 2); end
        n_checks++; if (bb !== (FWD ? 1 : 2)) begin n_fail++; $display("FAIL load_use_bubbles: got %0d expected %0d", bb, FWD ? 1 : 2); end
        n_checks++; if (hif.aluselectA !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL load_use_selA: got %0d expected %0d", hif.aluselectA, FWD ? 2 : 0); end
        n_checks++; if (hif.aluselectB !== (FWD ? 2'd2 : 2'd0)) begin n_fail++; $display("FAIL load_use_selB: got %0d expected %0d", hif.aluselectB, FWD ? 2 : 0); end
    endtask

    task automatic test_r0_and_priority();
        int st, bb;
        do_reset();
        send(1, 2, 1, 1, 0, 1, 0, st, bb);                // add r0,r1,r2
        send(0, 0, 1, 1, 4, 1, 0, st, bb);                // sub r4,r0,r0
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL r0_stalls: got %0d expected 0", st); end
        n_checks++; if (hif.aluselectA !== 2'd0) begin n_fail++; $display("FAIL r0_selA: got %0d expected 0", hif.aluselectA); end
        n_checks++; if (hif.aluselectB !== 2'd0) begin n_fail++; $display("FAIL r0_selB: got %0d expected 0", hif.aluselectB); end
        send(1, 2, 1, 1, 3, 1, 0, st, bb);                // add r3,r1,r2
        send(4, 5, 1, 1, 3, 1, 0, st, bb);                // add r3,r4,r5
        send(3, 1, 1, 1, 7, 1, 0, st, bb);                // add r7,r3,r1
        n_checks++; if (st !== (FWD ? 0 : 2)) begin n_fail++; $display("FAIL prio_stalls: got %0d expected %0d", st, FWD ? 0 : 2); end
        n_checks++; if (hif.aluselectA !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL prio_selA: got %0d expected %0d", hif.aluselectA, FWD ? 1 : 0); end
        n_checks++; if (hif.aluselectB !== 2'd0) begin n_fail++; $display("FAIL prio_selB: got %0d expected 0", hif.aluselectB); end
    endtask

    task automatic test_flush();
        int st, bb;
        do_reset();
        send(1, 0, 1, 0, 8, 1, 1, st, bb);                // lw r8,0(r1)
        @(negedge clk);
        drive(8, 8, 1, 1, 9, 1, 0, 1'b1);                 // add r9,r8,r8 killed
        #1;
        n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL flush_stall: got %b expected 0", hif.stall); end
        n_checks++; if (hif.bubble !== 1'b1) begin n_fail++; $display("FAIL flush_bubble: got %b expected 1", hif.bubble); end
        @(posedge clk);
        #1;
        n_checks++; if (hif.aluselectA !== 2'd0) begin n_fail++; $display("FAIL flush_selA: got %0d expected 0", hif.aluselectA); end
        n_checks++; if (hif.aluselectB !== 2'd0) begin n_fail++; $display("FAIL flush_selB: got %0d expected 0", hif.aluselectB); end
        send(9, 9, 1, 1, 10, 1, 0, st, bb);               // reads r9 of the killed op
        n_checks++; if (st !== 0) begin n_fail++; $display("FAIL flush_untracked_stalls: got %0d expected 0", st); end
        n_checks++; if (hif.aluselectA !== 2'd0) begin n_fail++; $display("FAIL flush_untracked_selA: got %0d expected 0", hif.aluselectA); end
    endtask

    task automatic test_reset_mid_stall();
        int st, bb;
        do_reset();
        send(2, 3, 1, 1, 1, 1, 0, st, bb);                // add r1,r2,r3
        send(1, 0, 1, 0, 8, 1, 1, st, bb);                // lw r8,0(r1)
        n_checks++; if (hif.aluselectA !== (FWD ? 2'd1 : 2'd0)) begin n_fail++; $display("FAIL lw_selA: got %0d expected %0d", hif.aluselectA, FWD ? 1 : 0); end
        @(negedge clk);
        drive(8, 8, 1, 1, 9, 1, 0, 1'b0);                 // add r9,r8,r8
        rst = 1'b1;
        #1;
        n_checks++; if (hif.stall !== 1'b1) begin n_fail++; $display("FAIL midstall_stall: got %b expected 1", hif.stall); end
        @(posedge clk);
        #1;
        n_checks++; if (hif.stall !== 1'b0) begin n_fail++; $display("FAIL post_reset_stall: got %b expected 0", hif.stall); end
        n_checks++; if (hif.bubble !== 1'b0) begin n_fail++; $display("FAIL post_reset_bubble: got %b expected 0", hif.bubble); end
        n_checks++; if (hif.aluselectA !== 2'd0) begin n_fail++; $display("FAIL post_reset_selA: got %0d expected 0", hif.aluselectA); end
        n_checks++; if (hif.aluselectB !== 2'd0) begin n_fail++; $display("FAIL post_reset_selB: got %0d expected 0", hif.aluselectB); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        test_reset();
        test_ex_fwd();
        test_mem_fwd();
        test_load_use();
        test_r0_and_priority();
        test_flush();
        test_reset_mid_stall();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within 200000 time units");
        $fatal(1);
    end

endmodule
